cacheline_adaptor: RTL and testbench
====================================

Name: cacheline_adaptor

Overview:
- Sits directly downstream of the I/D memory arbiter and upstream of the burst-mode physical memory.
- Converts one line-wide read or write request (256-bit line, 32-bit address) into a 4-beat, 64-bit burst transaction.
- Returns a single-cycle completion response to the arbiter.
- Owns beat counting, line assembly/disassembly and address alignment.

Parameters:
s_offset, 5, line offset bits; the low s_offset address bits are forced to zero.
s_line, 256, line width in bits.
s_burst, 64, memory beat width in bits.
s_beats, s_line/s_burst (4), beats per line; must be an integer ≥ 2.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
line_i  input  s_line  write line from arbiter
line_o  output  s_line  assembled read line to arbiter
address_i  input  32  line request address
read_i  input  1  line read request, held until resp_o
write_i  input  1  line write request, held until resp_o
resp_o  output  1  one-cycle completion pulse
burst_i  input  s_burst  read beat from memory
burst_o  output  s_burst  write beat to memory
address_o  output  32  aligned burst address
read_o  output  1  burst read request
write_o  output  1  burst write request
resp_i  input  1  memory beat strobe, one per accepted beat

Behaviour:
- Single clock domain: clk. Reset is synchronous, active-high: rst.
- Reset (rst high at posedge):
  - State goes to IDLE; beat counter = 0; line buffer = 0; latched address = 0.
  - read_o, write_o and resp_o = 0. burst_o = 0. address_o = 0. line_o = 0.
  - Reset mid-burst abandons the transaction; the memory is reset with it.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - If read_i, latch {address_i[31:s_offset], 0}, clear the counter, go to READ.
  - Else if write_i, latch the address and line_i into the buffer, clear the counter, go to WRITE.
  - read_i and write_i together is illegal; read wins.
- READ:
  - read_o = 1 and address_o = latched address, every cycle in the state.
  - On each resp_i, buffer[k*s_burst +: s_burst] <= burst_i, where k = counter; counter then increments.
  - Cycles with resp_i low are stalls: no capture, no increment. Gaps between beats are legal.
  - On the resp_i with k = s_beats-1, go to DONE. read_o drops the next cycle.
- WRITE:
  - write_o = 1; address_o = latched address; burst_o = buffer[k*s_burst +: s_burst], driven combinationally from the counter.
  - Beat 0 is presented in the first WRITE cycle.
  - Advance k on each resp_i. On the resp_i with k = s_beats-1, go to DONE.
- DONE:
  - resp_o = 1 for exactly one cycle, then go to IDLE.
  - After a read, line_o = buffer, valid in the DONE cycle and held until the next read capture.
  - read_o and write_o are both 0 in DONE.
- Line_i and address_i are sampled only on acceptance; later changes are ignored until the next IDLE.
- The requester drops its request in the cycle after resp_o, so IDLE does not re-accept.
- Latency with zero-stall memory:
  - Request-to-read_o is 1 cycle.
  - Request-to-resp_o = s_beats + 2 cycles: 1 to leave IDLE, s_beats beats, 1 DONE.
- Beat order is ascending, little-endian within the line. The counter is $clog2(s_beats) bits and wraps to 0 only on reset or acceptance.
- resp_i outside READ/WRITE is ignored.

Decomposition:
- Package cacheline_adaptor_pkg holds:
  - the state enum (IDLE, READ, WRITE, DONE);
  - the beat-count constant;
  - the counter-width localparam derived from s_line/s_burst.
- Single module, no sub-module. The buffer, counter and FSM are tightly coupled, and an implementation of about 150 lines is expected.

Test Plan:
- Read, no stalls: read_i=1, address_i=0x0000_1234; burst_i beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on 4 consecutive resp_i.
  -> address_o = 0x0000_1220; read_o high for 4 cycles; resp_o at cycle 6; line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write: write_i=1, line_i = {64'hD, 64'hC, 64'hB, 64'hA}, address_i = 0x8000_0040.
  -> burst_o = A, B, C, D on successive resp_i; write_o drops after beat 3; one resp_o pulse.
- Stalled read: resp_i pattern 1,0,0,1,1,0,1.
  -> exactly 4 captures in the correct slots; resp_o occurs 1 cycle after the last resp_i.
- Reset mid-burst: rst after 2 read beats.
  -> next cycle: read_o = 0, resp_o = 0, line_o = 0. A following read of 0x40 completes normally with fresh data.
- read_i and write_i both high -> read_o asserted, write_o stays 0.
- address_i and line_i changed mid-write -> burst_o and address_o still reflect the originally latched values.

Source files
------------

// File: rtl/cacheline_adaptor_pkg.sv
// Shared constants and types for the cache-line to burst adaptor.
// Default geometry: 256-bit line, 64-bit beats, 32-byte aligned line addresses.
package cacheline_adaptor_pkg;

  localparam int unsigned OffsetBits = 5;
  localparam int unsigned LineBits   = 256;
  localparam int unsigned BurstBits  = 64;
  localparam int unsigned Beats      = LineBits / BurstBits;
  localparam int unsigned CntW       = $clog2(Beats);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } state_e;

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Bundles the arbiter-facing line request and the memory-facing burst bus.
// slave  : the adaptor's view (takes line requests and memory beats).
// master : the environment's view (arbiter plus burst memory).
// Signals:
//   line_i/address_i/read_i/write_i : line request from arbiter
//   line_o/resp_o                   : assembled read line and completion pulse
//   burst_o/address_o/read_o/write_o: burst request to memory
//   burst_i/resp_i                  : read beat and per-beat strobe from memory
interface cacheline_adaptor_if
  import cacheline_adaptor_pkg::*;
#(
  parameter int unsigned s_line  = LineBits,
  parameter int unsigned s_burst = BurstBits
);

  logic [s_line-1:0]  line_i;
  logic [s_line-1:0]  line_o;
  logic [31:0]        address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [s_burst-1:0] burst_i;
  logic [s_burst-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );

endinterface

// File: rtl/cacheline_adaptor.sv
// Converts one line-wide read or write into an ascending burst of s_beats
// beats of s_burst bits, then returns a one-cycle resp_o to the arbiter.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset; abandons any burst in flight
//   bus  : cacheline_adaptor_if.slave (line request side and burst side)
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int unsigned s_offset = OffsetBits,
  parameter int unsigned s_line   = LineBits,
  parameter int unsigned s_burst  = BurstBits
) (
  input logic                clk,
  input logic                rst,
  cacheline_adaptor_if.slave bus
);

  localparam int unsigned s_beats = s_line / s_burst;
  localparam int unsigned cnt_w   = $clog2(s_beats);
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(s_beats - 1);
  localparam logic [31:0] addr_mask = ~((32'd1 << s_offset) - 32'd1);

  state_e            state_q;
  logic [cnt_w-1:0]  cnt_q;
  logic [31:0]       addr_q;
  // Read and write lines are kept apart so line_o survives an intervening write.
  logic [s_line-1:0] rline_q;
  logic [s_line-1:0] wline_q;
  logic              read_q;
  logic              write_q;
  logic              resp_q;

  logic [31:0]       addr_aligned;
  logic [31:0]       beat_lsb;

  assign addr_aligned = bus.address_i & addr_mask;
  assign beat_lsb     = 32'(cnt_q) * s_burst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      rline_q <= '0;
      wline_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Read has priority when both requests are raised together.
          if (bus.read_i) begin
            addr_q  <= addr_aligned;
            cnt_q   <= '0;
            read_q  <= 1'b1;
            state_q <= StRead;
          end else if (bus.write_i) begin
            addr_q  <= addr_aligned;
            wline_q <= bus.line_i;
            cnt_q   <= '0;
            write_q <= 1'b1;
            state_q <= StWrite;
          end
        end
        StRead: begin
          if (bus.resp_i) begin
            rline_q[beat_lsb +: s_burst] <= bus.burst_i;
            if (cnt_q == last_beat) begin
              read_q  <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StWrite: begin
          if (bus.resp_i) begin
            if (cnt_q == last_beat) begin
              write_q <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StDone: begin
          resp_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.read_o    = read_q;
  assign bus.write_o   = write_q;
  assign bus.resp_o    = resp_q;
  assign bus.address_o = addr_q;
  assign bus.line_o    = rline_q;
  // Current write beat follows the counter directly so beat 0 is on the bus
  // in the first WRITE cycle.
  assign bus.burst_o   = write_q ? wline_q[beat_lsb +: s_burst] : '0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
module tb_cacheline_adaptor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cacheline_adaptor_if bus ();

  cacheline_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Observations of the last transaction run by run_line.
  logic [63:0] rd_beats   [4];
  logic [63:0] seen_beats [4];
  int          n_seen;
  int          rd_hi, wr_hi, resp_cyc, last_cyc;
  logic [31:0] addr_seen;
  logic        done_rd, done_wr;

  // Drives one line request from IDLE and plays the memory side using the
  // resp_i pattern pat (bit j = cycle j after acceptance; 1 beyond plen).
  // Returns in the resp_o cycle with the request already dropped.
  task automatic run_line(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [255:0] line, input logic [15:0] pat,
                          input int plen, input bit scramble);
    int nb = 0;
    int j = 0;
    int cyc = 0;
    rd_hi = 0; wr_hi = 0; resp_cyc = -1; last_cyc = -1; n_seen = 0;
    addr_seen = '0; done_rd = 1'b0; done_wr = 1'b0;
    bus.read_i = rd; bus.write_i = wr; bus.address_i = addr; bus.line_i = line;
    while (cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (scramble && cyc == 1) begin
        bus.address_i = ~addr;
        bus.line_i    = ~line;
      end
      if (bus.resp_o) begin
        resp_cyc = cyc;
        done_rd  = bus.read_o;
        done_wr  = bus.write_o;
        break;
      end
      if (bus.read_o) rd_hi++;
      if (bus.write_o) wr_hi++;
      addr_seen   = bus.address_o;
      bus.resp_i  = (j < plen) ? pat[j] : 1'b1;
      bus.burst_i = bus.resp_i ? rd_beats[nb % 4] : 64'hdead_beef_dead_beef;
      if (bus.resp_i) begin
        last_cyc = cyc;
        if (bus.write_o && n_seen < 4) begin
          seen_beats[n_seen] = bus.burst_o;
          n_seen++;
        end
        nb++;
      end
      j++;
    end
    bus.resp_i = 1'b0; bus.burst_i = '0; bus.read_i = 1'b0; bus.write_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.read_o !== 1'b0 || bus.write_o !== 1'b0 || bus.resp_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got rd=%b wr=%b resp=%b, need 0 0 0",
               bus.read_o, bus.write_o, bus.resp_o);
    end
    checks++;
    if (bus.line_o !== '0 || bus.burst_o !== '0 || bus.address_o !== '0) begin
      errors++;
      $display("FAIL reset_data: got line=%h burst=%h addr=%h, need zeros",
               bus.line_o, bus.burst_o, bus.address_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_read_no_stall();
    logic [255:0] exp_line;
    rd_beats[0] = {16{4'h1}}; rd_beats[1] = {16{4'h2}};
    rd_beats[2] = {16{4'h3}}; rd_beats[3] = {16{4'h4}};
    exp_line = {rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]};
    run_line(1'b1, 1'b0, 32'h0000_1234, '0, 16'h000f, 4, 1'b0);
    checks++;
    if (addr_seen !== 32'h0000_1220) begin
      errors++;
      $display("FAIL read_addr: got %h need %h", addr_seen, 32'h0000_1220);
    end
    checks++;
    if (rd_hi !== 4 || wr_hi !== 0) begin
      errors++;
      $display("FAIL read_req_cycles: got rd=%0d wr=%0d need 4 0", rd_hi, wr_hi);
    end
    // resp_o in the 6th cycle counting the request cycle as the 1st.
    checks++;
    if (resp_cyc !== 5) begin
      errors++;
      $display("FAIL read_latency: got %0d need 5 edges after request", resp_cyc);
    end
    checks++;
    if (bus.line_o !== exp_line || done_rd !== 1'b0) begin
      errors++;
      $display("FAIL read_line: got %h rd=%b need %h rd=0", bus.line_o, done_rd, exp_line);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.resp_o !== 1'b0 || bus.read_o !== 1'b0 || bus.line_o !== exp_line) begin
      errors++;
      $display("FAIL read_after_done: got resp=%b rd=%b line=%h", bus.resp_o, bus.read_o,
               bus.line_o);
    end
  endtask

  task automatic test_write();
    logic [255:0] wl;
    logic [255:0] held;
    held = bus.line_o;
    wl = {64'hD, 64'hC, 64'hB, 64'hA};
    run_line(1'b0, 1'b1, 32'h8000_0040, wl, 16'h000f, 4, 1'b0);
    checks++;
    if (seen_beats[0] !== 64'hA || seen_beats[1] !== 64'hB ||
        seen_beats[2] !== 64'hC || seen_beats[3] !== 64'hD || n_seen !== 4) begin
      errors++;
      $display("FAIL write_beats: got n=%0d %h %h %h %h need A B C D", n_seen,
               seen_beats[0], seen_beats[1], seen_beats[2], seen_beats[3]);
    end
    checks++;
    if (wr_hi !== 4 || rd_hi !== 0 || resp_cyc !== 5 || done_wr !== 1'b0) begin
      errors++;
      $display("FAIL write_ctrl: got wr=%0d rd=%0d resp@%0d done_wr=%b need 4 0 5 0",
               wr_hi, rd_hi, resp_cyc, done_wr);
    end
    checks++;
    if (addr_seen !== 32'h8000_0040 || bus.line_o !== held) begin
      errors++;
      $display("FAIL write_addr_line: got addr=%h line=%h", addr_seen, bus.line_o);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.resp_o !== 1'b0 || bus.write_o !== 1'b0) begin
      errors++;
      $display("FAIL write_single_pulse: got resp=%b wr=%b need 0 0", bus.resp_o, bus.write_o);
    end
  endtask

  task automatic test_stalled_read();
    logic [255:0] exp_line;
    rd_beats[0] = 64'h0123_4567_89ab_cdef; rd_beats[1] = 64'hfedc_ba98_7654_3210;
    rd_beats[2] = 64'h0f0f_0f0f_f0f0_f0f0; rd_beats[3] = 64'h5555_aaaa_3333_cccc;
    exp_line = {rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]};
    // resp_i pattern 1,0,0,1,1,0,1
    run_line(1'b1, 1'b0, 32'h0000_0a5f, '0, 16'b1011001, 7, 1'b0);
    checks++;
    if (bus.line_o !== exp_line) begin
      errors++;
      $display("FAIL stall_line: got %h need %h", bus.line_o, exp_line);
    end
    checks++;
    if (rd_hi !== 7 || last_cyc !== 7 || resp_cyc !== 8) begin
      errors++;
      $display("FAIL stall_timing: got rd=%0d last=%0d resp=%0d need 7 7 8",
               rd_hi, last_cyc, resp_cyc);
    end
    checks++;
    if (addr_seen !== 32'h0000_0a40) begin
      errors++;
      $display("FAIL stall_addr: got %h need %h", addr_seen, 32'h0000_0a40);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_burst();
    logic [255:0] exp_line;
    bus.read_i = 1'b1; bus.address_i = 32'h0000_0100;
    @(posedge clk); #1;
    bus.resp_i = 1'b1; bus.burst_i = 64'h1111_2222_3333_4444;
    @(posedge clk); #1;
    bus.burst_i = 64'h5555_6666_7777_8888;
    @(posedge clk); #1;
    bus.resp_i = 1'b0; bus.read_i = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (bus.read_o !== 1'b0 || bus.resp_o !== 1'b0 || bus.line_o !== '0) begin
      errors++;
      $display("FAIL midreset: got rd=%b resp=%b line=%h need 0 0 0",
               bus.read_o, bus.resp_o, bus.line_o);
    end
    rd_beats[0] = '1; rd_beats[1] = 64'h1; rd_beats[2] = 64'h2; rd_beats[3] = 64'h3;
    exp_line = {rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]};
    run_line(1'b1, 1'b0, 32'h0000_0040, '0, 16'h000f, 4, 1'b0);
    checks++;
    if (bus.line_o !== exp_line || resp_cyc !== 5 || addr_seen !== 32'h40) begin
      errors++;
      $display("FAIL midreset_reread: got line=%h resp@%0d addr=%h", bus.line_o,
               resp_cyc, addr_seen);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_both_requests();
    rd_beats[0] = 64'hA0; rd_beats[1] = 64'hA1; rd_beats[2] = 64'hA2; rd_beats[3] = 64'hA3;
    run_line(1'b1, 1'b1, 32'h0000_2000, {4{64'hffff}}, 16'h000f, 4, 1'b0);
    checks++;
    if (rd_hi !== 4 || wr_hi !== 0) begin
      errors++;
      $display("FAIL both_req: got rd=%0d wr=%0d need 4 0", rd_hi, wr_hi);
    end
    checks++;
    if (bus.line_o !== {64'hA3, 64'hA2, 64'hA1, 64'hA0}) begin
      errors++;
      $display("FAIL both_req_line: got %h", bus.line_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_scramble();
    logic [255:0] wl;
    wl = {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003,
          64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001};
    // resp_i pattern 0,1,0,1,1,1
    run_line(1'b0, 1'b1, 32'h8000_0040, wl, 16'b111010, 6, 1'b1);
    checks++;
    if (seen_beats[0] !== wl[63:0] || seen_beats[1] !== wl[127:64] ||
        seen_beats[2] !== wl[191:128] || seen_beats[3] !== wl[255:192]) begin
      errors++;
      $display("FAIL scramble_beats: got %h %h %h %h", seen_beats[0], seen_beats[1],
               seen_beats[2], seen_beats[3]);
    end
    checks++;
    if (addr_seen !== 32'h8000_0040 || wr_hi !== 6 || resp_cyc !== 7) begin
      errors++;
      $display("FAIL scramble_addr: got addr=%h wr=%0d resp@%0d need 80000040 6 7",
               addr_seen, wr_hi, resp_cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_idle_resp_ignored();
    bus.resp_i = 1'b1; bus.burst_i = '1;
    repeat (2) @(posedge clk);
    #1;
    bus.resp_i = 1'b0;
    checks++;
    if (bus.resp_o !== 1'b0 || bus.read_o !== 1'b0 || bus.write_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_resp: got resp=%b rd=%b wr=%b need 0 0 0",
               bus.resp_o, bus.read_o, bus.write_o);
    end
  endtask

  initial begin
    bus.read_i = 1'b0; bus.write_i = 1'b0; bus.resp_i = 1'b0;
    bus.address_i = '0; bus.line_i = '0; bus.burst_i = '0;
    test_reset();
    test_read_no_stall();
    test_write();
    test_stalled_read();
    test_reset_mid_burst();
    test_both_requests();
    test_write_scramble();
    test_idle_resp_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
